// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built from one SLICE-bit carry-select slice reused over WORDS clocks, LSB slice first.
// Latency: out_valid rises WORDS clocks after the operand acceptance edge; one op per WORDS+2 clocks.
// Backpressure: in_ready only in IDLE without flush; result held in DONE until out_ready.
module wide_add_sequencer #(
    parameter int WORDS = 4,
    parameter int SLICE = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sub,
    input  logic                     c_in,
    input  logic [WORDS*SLICE-1:0]   a,
    input  logic [WORDS*SLICE-1:0]   b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*SLICE-1:0]   s,
    output logic                     c_out,
    output logic                     ovf,
    output logic                     busy
);

    localparam int W  = WORDS * SLICE;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic              carry_q;
    logic [W-1:0]      opa_q;
    logic [W-1:0]      opb_q;
    logic [W-1:0]      s_q;
    logic              c_out_q;
    logic              ovf_q;

    logic [SLICE-1:0]  sl_a;
    logic [SLICE-1:0]  sl_b;
    logic [SLICE:0]    sum0_d;
    logic [SLICE:0]    sum1_d;
    logic [SLICE:0]    slice_d;

    // Carry-select slice: both carry-in cases are formed, the registered carry picks one.
    always_comb begin
        sl_a    = opa_q[int'(idx_q)*SLICE +: SLICE];
        sl_b    = opb_q[int'(idx_q)*SLICE +: SLICE];
        sum0_d  = {1'b0, sl_a} + {1'b0, sl_b};
        sum1_d  = {1'b0, sl_a} + {1'b0, sl_b} + (SLICE+1)'(1);
        slice_d = carry_q ? sum1_d : sum0_d;
    end

    // Control FSM plus operand/result registers; flush aborts but leaves the last result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        opa_q   <= a;
                        // Subtraction is a + ~b + 1, so invert b once here.
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub | c_in;
                        idx_q   <= '0;
                        s_q     <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    s_q[int'(idx_q)*SLICE +: SLICE] <= slice_d[SLICE-1:0];
                    carry_q <= slice_d[SLICE];
                    if (idx_q == LAST_IDX) begin
                        c_out_q <= slice_d[SLICE];
                        ovf_q   <= (opa_q[W-1] == opb_q[W-1]) &&
                                   (slice_d[SLICE-1] != opa_q[W-1]);
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs wide add/subtract by sequencing one SLICE-bit carry-select adder slice over WORDS cycles, least significant slice first.
- A registered carry links consecutive slices.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.
- Lets the datapath share one narrow adder instead of instantiating a full-width one.

Parameters:
- WORDS, 4, number of slices per operation (must be ≥1; counter width is clog2(WORDS), min 1).
- SLICE, 10, bits per slice (matches the 10-bit adder slice).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns block to IDLE
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- sub  input  1  0 = a+b+c_in, 1 = a−b (c_in ignored)
- c_in  input  1  carry into slice 0 when sub=0
- a  input  WORDS*SLICE  operand A
- b  input  WORDS*SLICE  operand B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- s  output  WORDS*SLICE  sum/difference
- c_out  output  1  carry out of MSB slice
- ovf  output  1  two's-complement overflow
- busy  output  1  high in ADD or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry=0, s=0, c_out=0, ovf=0, out_valid=0, busy=0, in_ready=1 after reset release.
- States: IDLE, ADD, DONE.
- in_ready = (state==IDLE) && !flush.
- out_valid = (state==DONE).
- busy = (state!=IDLE).

IDLE:
- Transfer occurs on in_valid && in_ready at a rising edge.
- On transfer, latch a into opa.
- Latch b into opb; when sub=1, latch ~b instead.
- Set carry = sub ? 1 : c_in, idx=0, s=0, then go to ADD.
- Inputs are sampled only at the transfer edge; later changes have no effect.

ADD (one slice per clock):
- opa slice idx + opb slice idx + carry is written to s slice idx.
- carry ← slice carry-out, idx ← idx+1.
- When idx==WORDS−1, on that edge:
  - c_out ← slice carry-out.
  - ovf ← (opa MSB == opb MSB) && (result MSB != opa MSB).
  - Go to DONE.

Timing:
- Latency: out_valid rises exactly WORDS clocks after the acceptance edge.
- Throughput: one operation per WORDS+2 clocks. There is a mandatory IDLE cycle after each result handshake; no bypass.

DONE:
- s, c_out, ovf held stable while out_valid && !out_ready.
- On out_ready, go to IDLE. s, c_out, ovf keep their values until the next acceptance.

Arithmetic:
- Results are modulo 2^(WORDS*SLICE).
- For sub=1, c_out=1 means no borrow (a ≥ b unsigned).

flush:
- Synchronous; priority over all handshakes.
- Forces IDLE, out_valid=0, idx=0, carry=0 on the next edge. s, c_out, ovf are unchanged.
- A flush concurrent with in_valid does not accept the operation; in_ready is low that cycle.

WORDS=1: ADD lasts one cycle. Behaviour is otherwise identical.

Reset asserted mid-ADD or mid-DONE: immediate return to reset values; the in-flight operation is lost.

Test Plan (WORDS=4, SLICE=10):
1. Carry ripple: a=40'hFF_FFFF_FFFF, b=1, sub=0, c_in=0 -> out_valid exactly 4 clocks after acceptance; s=0, c_out=1, ovf=0.
2. Signed overflow: a=40'h7F_FFFF_FFFF, b=0, c_in=1 -> s=40'h80_0000_0000, c_out=0, ovf=1.
3. Subtract with borrow: a=5, b=7, sub=1, c_in=1 -> s=40'hFF_FFFF_FFFE, c_out=0, ovf=0, proving c_in is ignored.
4. Backpressure: a=40'h00_0000_03FF, b=1, out_ready low for 5 cycles after out_valid -> s=40'h400 held stable and in_ready=0 throughout. After out_ready, one IDLE cycle with in_ready=1, then a new operation is accepted.
5. Flush and reset mid-operation:
   - flush pulse at idx=2 -> IDLE next edge, no out_valid.
   - Next op a=3, b=4 gives s=7.
   - Separately, rst_n low during ADD -> all outputs 0 immediately, in_ready=1 after release.
6. Input stability: change a and b during ADD after accepting a=100, b=23 -> s=123, showing operands are latched only at acceptance.
